// File: rtl/cpu_sequencer.sv
// Eight-phase instruction sequencer for the 8-bit RISC CPU: phase counter plus halt flag,
// decoded into datapath strobes. Optional resume-from-halt port under `CPU_SEQ_RESUME_EN`.
module cpu_sequencer #(
    parameter int OPCODE_W = 3,
    parameter int PHASE_W  = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
`ifdef CPU_SEQ_RESUME_EN
    input  logic                resume,
`endif
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                halt,
    output logic                inc_pc,
    output logic                ld_pc,
    output logic                ld_ac,
    output logic                wr,
    output logic                data_e,
    output logic [PHASE_W-1:0]  phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   resume_s;
    logic   aluop_s;

`ifdef CPU_SEQ_RESUME_EN
    assign resume_s = resume;
`else
    assign resume_s = 1'b0;
`endif

    assign aluop_s = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);
    assign phase   = phase_q;

    // State register: phase counter and halted flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Next state: advance while enabled and running; halt latches on leaving OP_ADDR
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (halted_q) begin
            if (resume_s) begin
                halted_d = 1'b0;
                phase_d  = INST_ADDR;
            end else begin
                halted_d = 1'b1;
            end
        end else if (enable) begin
            phase_d = phase_e'(phase_q + 3'd1);
            if ((phase_q == OP_ADDR) && (opcode == OP_HLT)) begin
                halted_d = 1'b1;
            end else begin
                halted_d = 1'b0;
            end
        end else begin
            phase_d = phase_q;
        end
    end

    // Output decode from registered phase/halted, then halt and stall overrides
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        case (phase_q)
            INST_ADDR:  sel = 1'b1;
            INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
            INST_LOAD,
            IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
            OP_ADDR: begin
                inc_pc = (opcode != OP_HLT);
                halt   = (opcode == OP_HLT);
            end
            OP_FETCH:   rd = aluop_s;
            ALU_OP: begin
                rd     = aluop_s;
                inc_pc = (opcode == OP_SKZ) && zero;
                ld_pc  = (opcode == OP_JMP);
                data_e = (opcode == OP_STO);
            end
            STORE: begin
                rd     = aluop_s;
                ld_ac  = aluop_s;
                ld_pc  = (opcode == OP_JMP);
                wr     = (opcode == OP_STO);
                data_e = (opcode == OP_STO);
            end
            default: sel = 1'b0;
        endcase

        if (halted_q) begin
            // While halted only halt is shown; inc_pc marks the resume step past HLT
            sel    = 1'b0;
            rd     = 1'b0;
            ld_ir  = 1'b0;
            halt   = 1'b1;
            inc_pc = resume_s;
            ld_pc  = 1'b0;
            ld_ac  = 1'b0;
            wr     = 1'b0;
            data_e = 1'b0;
        end else if (!enable) begin
            // Stall kills state-changing strobes; sel/data_e/halt stay so the bus stays driven
            rd     = 1'b0;
            ld_ir  = 1'b0;
            inc_pc = 1'b0;
            ld_pc  = 1'b0;
            ld_ac  = 1'b0;
            wr     = 1'b0;
        end else begin
            halt = halt;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed steps plus randomized instruction
// streams checked against a rule-based behavioural model.
module tb_cpu_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] opcode = 3'd2;
    logic       zero = 1'b0;
    logic       resume = 1'b0;
    logic       sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e;
    logic [2:0] phase;

    int tests = 0;
    int fails = 0;

    // model state
    int m_phase = 0;
    bit m_halted = 1'b0;

    cpu_sequencer dut (
        .clock(clock), .reset(reset), .enable(enable), .opcode(opcode), .zero(zero),
`ifdef CPU_SEQ_RESUME_EN
        .resume(resume),
`endif
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc),
        .ld_pc(ld_pc), .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .phase(phase)
    );

    always #5 clock = ~clock;

    // Expected {sel,rd,ld_ir,halt,inc_pc,ld_pc,ld_ac,wr,data_e} from the written rules
    function automatic logic [8:0] expect_out(int ph, int op, bit z, bit h, bit en, bit res);
        bit alu, s, r, li, hl, ip, lp, la, w, de;
        alu = (op >= 2) && (op <= 5);
        if (h) return {1'b0, 1'b0, 1'b0, 1'b1, res, 1'b0, 1'b0, 1'b0, 1'b0};
        s  = (ph <= 3);
        r  = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        li = (ph == 2) || (ph == 3);
        hl = (ph == 4) && (op == 0);
        ip = (ph == 4 && op != 0) || (ph == 6 && op == 1 && z);
        lp = (ph >= 6) && (op == 7);
        la = (ph == 7) && alu;
        w  = (ph == 7) && (op == 6);
        de = (ph >= 6) && (op == 6);
        if (!en) begin r = 0; li = 0; ip = 0; lp = 0; la = 0; w = 0; end
        return {s, r, li, hl, ip, lp, la, w, de};
    endfunction

    task automatic check(string tag);
        logic [8:0] exp_v, got_v;
        bit res;
`ifdef CPU_SEQ_RESUME_EN
        res = resume;
`else
        res = 1'b0;
`endif
        exp_v = expect_out(m_phase, int'(opcode), zero, m_halted, enable, res);
        got_v = {sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e};
        tests++;
        assert (phase === 3'(m_phase)) else begin
            fails++;
            $error("FAIL %s phase: got %0d expected %0d", tag, phase, m_phase);
        end
        tests++;
        assert (got_v === exp_v) else begin
            fails++;
            $error("FAIL %s outputs(ph%0d op%0d): got %b expected %b", tag, m_phase, opcode, got_v, exp_v);
        end
    endtask

    // One clock: check at #1 after input change, clock edge, update model, return to negedge
    task automatic cycle(string tag, input logic [2:0] op, input logic z, input logic en);
        bit res;
        opcode = op; zero = z; enable = en;
        #1;
        check(tag);
        res = resume;
`ifndef CPU_SEQ_RESUME_EN
        res = 1'b0;
`endif
        @(posedge clock);
        if (m_halted) begin
            if (res) begin m_halted = 1'b0; m_phase = 0; end
        end else if (en) begin
            if (m_phase == 4 && op == 3'd0) m_halted = 1'b1;
            m_phase = (m_phase + 1) % 8;
        end
        @(negedge clock);
    endtask

    task automatic run_to(int p, input logic [2:0] op);
        for (int i = 0; i < 16 && m_phase != p; i++) cycle("run_to", op, 1'b0, 1'b1);
    endtask

    initial begin
        int pulses;
        logic [2:0] rop;

        // reset state
        #2;
        check("reset");
        @(negedge clock);
        reset = 1'b0;

        // ADD: full instruction and wrap to 0
        for (int i = 0; i < 9; i++) cycle("add", 3'd2, 1'b0, 1'b1);
        run_to(0, 3'd2);
        for (int i = 0; i < 8; i++) cycle("sto", 3'd6, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cycle("jmp", 3'd7, 1'b0, 1'b1);

        // SKZ pulse counts with zero set and clear
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            pulses += int'(inc_pc === 1'b1 && i > 0 ? 1 : 0);
            cycle("skz1", 3'd1, 1'b1, 1'b1);
        end
        pulses += int'(inc_pc === 1'b1 ? 1 : 0);
        tests++;
        assert (pulses === 2) else begin
            fails++; $error("FAIL skz_z1_pulses: got %0d expected 2", pulses);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cycle("skz0", 3'd1, 1'b0, 1'b1);
            pulses += int'(inc_pc === 1'b1 ? 1 : 0);
        end
        tests++;
        assert (pulses === 1) else begin
            fails++; $error("FAIL skz_z0_pulses: got %0d expected 1", pulses);
        end

        // stall in STORE with STO, then resume stepping
        run_to(0, 3'd6);
        run_to(7, 3'd6);
        for (int i = 0; i < 3; i++) cycle("stall", 3'd6, 1'b0, 1'b0);
        tests++;
        assert (wr === 1'b0 && data_e === 1'b1 && phase === 3'd7) else begin
            fails++; $error("FAIL stall_sto: got wr=%b data_e=%b phase=%0d expected 0 1 7", wr, data_e, phase);
        end
        for (int i = 0; i < 2; i++) cycle("restart", 3'd6, 1'b0, 1'b1);

        // randomized instruction stream (no HLT), random zero and enable
        rop = 3'd2;
        for (int i = 0; i < 400; i++) begin
            if (m_phase == 0) rop = 3'(1 + $urandom_range(6));
            cycle("rand", rop, 1'($urandom_range(1)), ($urandom_range(9) < 8));
        end

        // HLT: halt in OP_ADDR then frozen at phase 5
        run_to(0, 3'd2);
        for (int i = 0; i < 5; i++) cycle("hlt", 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cycle("halted", 3'(i % 8), 1'($urandom_range(1)), 1'($urandom_range(1)));
        tests++;
        assert (phase === 3'd5 && halt === 1'b1) else begin
            fails++; $error("FAIL halt_freeze: got phase=%0d halt=%b expected 5 1", phase, halt);
        end

`ifdef CPU_SEQ_RESUME_EN
        resume = 1'b1;
        cycle("resume", 3'd0, 1'b0, 1'b1);
        resume = 1'b0;
        cycle("post_resume", 3'd2, 1'b0, 1'b1);
        run_to(0, 3'd2);
        for (int i = 0; i < 6; i++) cycle("hlt2", 3'd0, 1'b0, 1'b1);
`endif

        // asynchronous reset while halted, no clock edge in between
        #2;
        reset = 1'b1;
        m_phase = 0; m_halted = 1'b0;
        #1;
        tests++;
        assert (phase === 3'd0 && halt === 1'b0 && sel === 1'b1) else begin
            fails++; $error("FAIL async_reset: got phase=%0d halt=%b sel=%b expected 0 0 1", phase, halt, sel);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) cycle("after_reset", 3'd5, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
